// File: rtl/sw_pio_poller.sv
// sw_pio_poller: Avalon-MM read master that polls the switch PIO data
// register, debounces the sampled value and publishes a stable switch
// vector together with one-cycle change, rise and fall pulses.
module sw_pio_poller #(
  parameter int WIDTH        = 10,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_COUNT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  output logic [WIDTH-1:0] sw_state,
  output logic             sw_changed,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             rd_timeout
);

  localparam int                DIV_W      = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(POLL_DIV - 1);
  localparam logic [3:0]        STABLE_N   = 4'(STABLE_COUNT);
  localparam logic [7:0]        TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] divider_q;
  logic [7:0]       timer_q;
  logic             avm_read_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sw_state_q;
  logic             sw_changed_q;
  logic [WIDTH-1:0] sw_rise_q, sw_fall_q;
  logic             rd_timeout_q;
  logic [WIDTH-1:0] sample;
  logic             commit;

  // Only the low WIDTH bits of the PIO data word carry switch state.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:WIDTH];

  assign sample      = avm_readdata[WIDTH-1:0];
  assign avm_address = 2'd0;
  assign avm_read    = avm_read_q;
  assign sw_state    = sw_state_q;
  assign sw_changed  = sw_changed_q;
  assign sw_rise     = sw_rise_q;
  assign sw_fall     = sw_fall_q;
  assign rd_timeout  = rd_timeout_q;

  // Debounce next-state: extend the run of identical samples or restart it.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sample == cand_q) begin
      cnt_d = (cnt_q >= STABLE_N) ? STABLE_N : cnt_q + 4'd1;
    end else begin
      cand_d = sample;
      cnt_d  = 4'd1;
    end
    commit = (cnt_d == STABLE_N) && (cand_d != sw_state_q);
  end

  // Poll sequencer, read handshake, timeout and debounced output registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      divider_q    <= DIV_RELOAD;
      timer_q      <= 8'd0;
      avm_read_q   <= 1'b0;
      cand_q       <= '0;
      cnt_q        <= 4'd0;
      sw_state_q   <= '0;
      sw_changed_q <= 1'b0;
      sw_rise_q    <= '0;
      sw_fall_q    <= '0;
      rd_timeout_q <= 1'b0;
    end else begin
      sw_changed_q <= 1'b0;
      sw_rise_q    <= '0;
      sw_fall_q    <= '0;
      rd_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (divider_q == '0) begin
            divider_q  <= DIV_RELOAD;
            avm_read_q <= 1'b1;
            state_q    <= ST_REQ;
          end else begin
            divider_q <= divider_q - 1'b1;
          end
        end
        ST_REQ: begin
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            timer_q    <= 8'd0;
            state_q    <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (avm_readdatavalid) begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            state_q <= ST_IDLE;
            if (commit) begin
              sw_state_q   <= cand_d;
              sw_changed_q <= 1'b1;
              sw_rise_q    <= cand_d & ~sw_state_q;
              sw_fall_q    <= ~cand_d & sw_state_q;
            end
          end else if (timer_q == TIMER_LAST) begin
            rd_timeout_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: begin
          avm_read_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_pio_poller.sv
// Self-checking bench for sw_pio_poller: a scripted Avalon slave answers each
// poll, and a sample-history model predicts debounce commits and poll timing.
module tb_sw_pio_poller;

  localparam int WIDTH = 10;
  localparam int PDIV  = 8;
  localparam int SC    = 4;
  localparam int TOUT  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       avm_address;
  logic             avm_read;
  logic             avm_waitrequest;
  logic [31:0]      avm_readdata;
  logic             avm_readdatavalid;
  logic [WIDTH-1:0] sw_state;
  logic             sw_changed;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             rd_timeout;

  sw_pio_poller #(.WIDTH(WIDTH), .POLL_DIV(PDIV), .STABLE_COUNT(SC), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .sw_state(sw_state), .sw_changed(sw_changed),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int idle_cyc = 0;   // posedge index at which the DUT last returned to idle
  int n_commit = 0;   // sw_changed pulses observed

  // Reference model: history of accepted samples and the published value.
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] m_state;

  // One complete poll: wait for the request, stall it, then answer or drop it.
  task automatic poll(input logic [WIDTH-1:0] data, input int waits, input bit give_valid);
    int n = 0;
    int acc_cyc;
    bit all_eq;
    bit exp_commit;
    logic [WIDTH-1:0] exp_rise, exp_fall;
    while (avm_read !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (avm_read !== 1'b1) begin
      bad++;
      $display("FAIL launch_wait: avm_read=%b after %0d cycles, want 1", avm_read, n);
      return;
    end
    total++;
    if (cyc !== idle_cyc + PDIV) begin
      bad++;
      $display("FAIL launch_spacing: read at cycle %0d, want %0d", cyc, idle_cyc + PDIV);
    end
    total++;
    if (avm_address !== 2'd0) begin
      bad++;
      $display("FAIL address: got %0d want 0", avm_address);
    end
    avm_waitrequest = (waits > 0);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      total++;
      if (avm_read !== 1'b1 || avm_address !== 2'd0) begin
        bad++;
        $display("FAIL req_hold: read=%b addr=%0d in stall cycle %0d, want 1/0", avm_read, avm_address, i);
      end
      if (i == waits - 1) avm_waitrequest = 1'b0;
    end
    @(negedge clk);
    total++;
    if (avm_read !== 1'b0) begin
      bad++;
      $display("FAIL req_drop: avm_read=%b after acceptance, want 0", avm_read);
    end
    if (give_valid) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = {22'($urandom), data};
      @(negedge clk);
      idle_cyc = cyc;
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      hist.push_back(data);
      if (hist.size() > 16) void'(hist.pop_front());
      exp_commit = 1'b0;
      if (hist.size() >= SC) begin
        all_eq = 1'b1;
        for (int k = 1; k <= SC; k++) if (hist[hist.size() - k] !== data) all_eq = 1'b0;
        exp_commit = all_eq && (data !== m_state);
      end
      exp_rise = exp_commit ? (data & ~m_state) : '0;
      exp_fall = exp_commit ? (~data & m_state) : '0;
      if (exp_commit) m_state = data;
      if (sw_changed === 1'b1) n_commit++;
      total++;
      if (sw_changed !== exp_commit || sw_state !== m_state || sw_rise !== exp_rise || sw_fall !== exp_fall) begin
        bad++;
        $display("FAIL sample_%h: chg=%b st=%h rise=%h fall=%h, want chg=%b st=%h rise=%h fall=%h",
                 data, sw_changed, sw_state, sw_rise, sw_fall, exp_commit, m_state, exp_rise, exp_fall);
      end
      @(negedge clk);
      total++;
      if (sw_changed !== 1'b0 || sw_rise !== '0 || sw_fall !== '0 || sw_state !== m_state) begin
        bad++;
        $display("FAIL pulse_end: chg=%b rise=%h fall=%h st=%h, want 0/0/0/%h",
                 sw_changed, sw_rise, sw_fall, sw_state, m_state);
      end
    end else begin
      acc_cyc = cyc;
      n = 0;
      while (rd_timeout !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
        total++;
        if (avm_read !== 1'b0) begin
          bad++;
          $display("FAIL no_second_req: avm_read=%b while read outstanding, want 0", avm_read);
        end
      end
      total++;
      if (rd_timeout !== 1'b1 || cyc !== acc_cyc + TOUT) begin
        bad++;
        $display("FAIL timeout_time: rd_timeout=%b at +%0d cycles, want 1 at +%0d", rd_timeout, cyc - acc_cyc, TOUT);
      end
      idle_cyc = cyc;
      total++;
      if (sw_state !== m_state || sw_changed !== 1'b0) begin
        bad++;
        $display("FAIL timeout_state: st=%h chg=%b, want %h/0", sw_state, sw_changed, m_state);
      end
      @(negedge clk);
      total++;
      if (rd_timeout !== 1'b0) begin
        bad++;
        $display("FAIL timeout_pulse: rd_timeout=%b, want 0", rd_timeout);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    repeat (3) @(negedge clk);
    total++;
    if (avm_read !== 1'b0 || avm_address !== 2'd0 || sw_state !== '0 || sw_changed !== 1'b0 ||
        sw_rise !== '0 || sw_fall !== '0 || rd_timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: read=%b addr=%0d st=%h chg=%b rise=%h fall=%h to=%b, want all 0",
               avm_read, avm_address, sw_state, sw_changed, sw_rise, sw_fall, rd_timeout);
    end
    reset = 1'b0;
    idle_cyc = cyc;
    hist.delete();
    m_state = '0;
  endtask

  task automatic test_poll_spacing();
    for (int i = 0; i < 3; i++) poll(10'h000, 0, 1'b1);
  endtask

  task automatic test_debounce_rise();
    int c0 = n_commit;
    for (int i = 0; i < 4; i++) poll(10'h2A5, 0, 1'b1);
    total++;
    if (n_commit - c0 !== 1 || sw_state !== 10'h2A5) begin
      bad++;
      $display("FAIL rise_commit: commits=%0d st=%h, want 1/2a5", n_commit - c0, sw_state);
    end
  endtask

  task automatic test_debounce_fall();
    logic [WIDTH-1:0] seq [6];
    int c0 = n_commit;
    seq = '{10'h2A4, 10'h2A5, 10'h2A4, 10'h2A4, 10'h2A4, 10'h2A4};
    for (int i = 0; i < 6; i++) poll(seq[i], 0, 1'b1);
    total++;
    if (n_commit - c0 !== 1 || sw_state !== 10'h2A4) begin
      bad++;
      $display("FAIL fall_commit: commits=%0d st=%h, want 1/2a4", n_commit - c0, sw_state);
    end
  endtask

  task automatic test_waitrequest();
    poll(10'h2A4, 5, 1'b1);
  endtask

  task automatic test_timeout();
    poll(10'h155, 1, 1'b0);
    poll(10'h2A4, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int c0;
    while (avm_read !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    avm_waitrequest = 1'b1;
    @(negedge clk);
    total++;
    if (avm_read !== 1'b1) begin
      bad++;
      $display("FAIL stall_hold: avm_read=%b, want 1", avm_read);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (avm_read !== 1'b0 || sw_state !== '0) begin
      bad++;
      $display("FAIL reset_mid: read=%b st=%h, want 0/000", avm_read, sw_state);
    end
    reset = 1'b0;
    idle_cyc = cyc;
    hist.delete();
    m_state = '0;
    @(negedge clk);
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0000_03FF;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    total++;
    if (sw_state !== '0 || sw_changed !== 1'b0) begin
      bad++;
      $display("FAIL late_valid: st=%h chg=%b, want 000/0", sw_state, sw_changed);
    end
    // The stray sample must not count toward the debounce run.
    c0 = n_commit;
    for (int i = 0; i < 3; i++) poll(10'h3FF, 0, 1'b1);
    total++;
    if (n_commit !== c0 || sw_state !== '0) begin
      bad++;
      $display("FAIL stray_ignored: commits=%0d st=%h, want 0/000", n_commit - c0, sw_state);
    end
    poll(10'h3FF, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] v = 10'h155;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : 10'h2A5;
      poll(v, $urandom_range(0, 3), $urandom_range(0, 7) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_poll_spacing();
    test_debounce_rise();
    test_debounce_fall();
    test_waitrequest();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
